board_renderer: RTL and testbench

- Upstream sequencer for the square filler: walks the Tetris playfield cell by cell, reads each cell's colour from the board RAM, and launches one 23x23-pixel square fill per cell.
- Waits for the filler's done pulse before moving to the next cell.
- Drives the filler's reference corner and start strobe, and tags the drawn pixels with the cell colour.
- Sits between the game-logic board memory and the square filler/line-drawer chain feeding the framebuffer.

---
 rtl/board_renderer.sv | 141 ++++++++++++++
 tb/tb_board_renderer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_renderer.sv
// board_renderer: walks the playfield RAM cell by cell and launches
// one square fill per drawn cell, waiting for the filler between cells.
module board_renderer #(
  parameter int          COLS       = 10,
  parameter int          ROWS       = 20,
  parameter logic [10:0] X0         = 11'd25,
  parameter logic [10:0] Y0         = 11'd1,
  parameter logic [10:0] PITCH      = 11'd24,
  parameter bit          DRAW_EMPTY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  cell_addr,
  input  logic [2:0]  cell_data,
  output logic        sq_start,
  output logic [10:0] refX,
  output logic [10:0] refY,
  input  logic        doneSq,
  output logic [2:0]  pix_color,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RD,
    S_LAUNCH,
    S_FILL,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    addr_q, addr_d;
  logic [10:0]   refx_q, refx_d;
  logic [10:0]   refy_q, refy_d;
  logic [2:0]    color_q, color_d;

  logic col_last;
  logic cell_last;

  assign col_last  = (col_q == COL_LAST);
  assign cell_last = col_last && (row_q == ROW_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      refx_q  <= X0;
      refy_q  <= Y0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      refx_q  <= refx_d;
      refy_q  <= refy_d;
      color_q <= color_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    refx_d  = refx_q;
    refy_d  = refy_q;
    color_d = color_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        color_d = cell_data;
        if ((cell_data != 3'd0) || DRAW_EMPTY)
          state_d = S_LAUNCH;
        else
          state_d = S_ADVANCE;
      end
      S_LAUNCH: begin
        state_d = S_FILL;
      end
      S_FILL: begin
        if (doneSq) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        // corners are running sums; no row*PITCH product anywhere
        if (col_last) begin
          col_d  = '0;
          refx_d = X0;
          row_d  = row_q + RW'(1);
          refy_d = refy_q + PITCH;
        end else begin
          col_d  = col_q + CW'(1);
          refx_d = refx_q + PITCH;
        end
        addr_d = addr_q + 8'd1;
        if (cell_last)
          state_d = S_DONE;
        else
          state_d = S_FETCH;
      end
      S_DONE: begin
        col_d   = '0;
        row_d   = '0;
        addr_d  = '0;
        refx_d  = X0;
        refy_d  = Y0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cell_addr  = addr_q;
  assign refX       = refx_q;
  assign refY       = refy_q;
  assign pix_color  = color_q;
  assign sq_start   = (state_q == S_LAUNCH);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_board_renderer.sv
// tb_board_renderer: two renderers (skip-empty and draw-empty) share one
// board image; launches and frame timing are compared to a cell-list model.
module tb_board_renderer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start;
  logic [7:0]  a0, a1;
  logic [2:0]  d0, d1, pc0, pc1;
  logic        sq0, sq1, b0, b1, fd0, fd1;
  logic [10:0] rx0, ry0, rx1, ry1;
  logic        dn0, dn1;
  logic        md0 = 1'b0, md1 = 1'b0;
  logic        sp0 = 1'b0, sp1 = 1'b0;
  logic        bp0 = 1'b0, bp1 = 1'b0;
  int cnt0 = 0, cnt1 = 0;
  int dly = 5;
  int cyc = 0;
  bit spur_en = 1'b0;
  logic [2:0] board [256];

  typedef struct {
    int inst;
    int cyc;
    int x;
    int y;
    int c;
    int a;
  } ev_t;
  ev_t evq[$];

  int checks = 0;
  int errors = 0;
  int hx0, hy0, hc0, hx1, hy1, hc1;
  int fdc0, fdc1, bfc0, bfc1;

  board_renderer #(.DRAW_EMPTY(1'b0)) u0 (
    .clk(clk), .reset(rst), .start(start),
    .cell_addr(a0), .cell_data(d0),
    .sq_start(sq0), .refX(rx0), .refY(ry0),
    .doneSq(dn0), .pix_color(pc0),
    .busy(b0), .frame_done(fd0)
  );

  board_renderer #(.DRAW_EMPTY(1'b1)) u1 (
    .clk(clk), .reset(rst), .start(start),
    .cell_addr(a1), .cell_data(d1),
    .sq_start(sq1), .refX(rx1), .refY(ry1),
    .doneSq(dn1), .pix_color(pc1),
    .busy(b1), .frame_done(fd1)
  );

  // spurious pulses only reach a DUT while its filler is idle
  assign dn0 = md0 | (sp0 & (cnt0 == 0));
  assign dn1 = md1 | (sp1 & (cnt1 == 0));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    d0  <= board[a0];
    d1  <= board[a1];
    sp0 <= spur_en & 1'($urandom_range(0, 1));
    sp1 <= spur_en & 1'($urandom_range(0, 1));
    md0 <= 1'b0;
    md1 <= 1'b0;
    if (rst) begin
      cnt0 <= 0;
      cnt1 <= 0;
    end else begin
      if (sq0 === 1'b1) cnt0 <= dly;
      else if (cnt0 > 0) begin
        if (cnt0 == 2) md0 <= 1'b1;
        cnt0 <= cnt0 - 1;
      end
      if (sq1 === 1'b1) cnt1 <= dly;
      else if (cnt1 > 0) begin
        if (cnt1 == 2) md1 <= 1'b1;
        cnt1 <= cnt1 - 1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sq0 === 1'b1) begin
      evq.push_back('{0, cyc, int'(rx0), int'(ry0), int'(pc0), int'(a0)});
      hx0 = int'(rx0); hy0 = int'(ry0); hc0 = int'(pc0);
    end
    if (sq1 === 1'b1) begin
      evq.push_back('{1, cyc, int'(rx1), int'(ry1), int'(pc1), int'(a1)});
      hx1 = int'(rx1); hy1 = int'(ry1); hc1 = int'(pc1);
    end
    if (cnt0 > 0) begin
      chk("u0_hold_x", 32'(rx0), hx0);
      chk("u0_hold_y", 32'(ry0), hy0);
      chk("u0_hold_c", 32'(pc0), hc0);
    end
    if (cnt1 > 0) begin
      chk("u1_hold_x", 32'(rx1), hx1);
      chk("u1_hold_y", 32'(ry1), hy1);
      chk("u1_hold_c", 32'(pc1), hc1);
    end
    if (fd0 === 1'b1) fdc0 = cyc;
    if (fd1 === 1'b1) fdc1 = cyc;
    if (bp0 === 1'b1 && b0 === 1'b0) bfc0 = cyc;
    if (bp1 === 1'b1 && b1 === 1'b0) bfc1 = cyc;
    bp0 = b0;
    bp1 = b1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_idle(input string p);
    chk({p, "_u0_busy"}, 32'(b0), 0);
    chk({p, "_u0_sq"},   32'(sq0), 0);
    chk({p, "_u0_fd"},   32'(fd0), 0);
    chk({p, "_u0_x"},    32'(rx0), 25);
    chk({p, "_u0_y"},    32'(ry0), 1);
    chk({p, "_u0_addr"}, 32'(a0), 0);
    chk({p, "_u0_col"},  32'(pc0), 0);
    chk({p, "_u1_busy"}, 32'(b1), 0);
    chk({p, "_u1_sq"},   32'(sq1), 0);
    chk({p, "_u1_fd"},   32'(fd1), 0);
    chk({p, "_u1_x"},    32'(rx1), 25);
    chk({p, "_u1_y"},    32'(ry1), 1);
    chk({p, "_u1_addr"}, 32'(a1), 0);
    chk({p, "_u1_col"},  32'(pc1), 0);
  endtask

  // model: a cell costs 3 cycles if skipped, dly+4 if filled
  task automatic compare(input string p, input int g, input int c0);
    ev_t ex[$];
    ev_t ob[$];
    int t;
    int fdc, bfc;
    t = 1;
    for (int i = 0; i < 200; i++) begin
      bit l;
      l = (board[i] != 3'd0) || (g == 1);
      if (l)
        ex.push_back('{g, t + 2, 25 + 24 * (i % 10), 1 + 24 * (i / 10),
                       int'(board[i]), i});
      t += l ? dly + 4 : 3;
    end
    foreach (evq[k]) if (evq[k].inst == g) ob.push_back(evq[k]);
    chk($sformatf("%s_u%0d_nlaunch", p, g), ob.size(), ex.size());
    for (int k = 0; k < ex.size() && k < ob.size(); k++) begin
      chk($sformatf("%s_u%0d_cyc[%0d]", p, g, k), ob[k].cyc - c0, ex[k].cyc);
      chk($sformatf("%s_u%0d_x[%0d]", p, g, k), ob[k].x, ex[k].x);
      chk($sformatf("%s_u%0d_y[%0d]", p, g, k), ob[k].y, ex[k].y);
      chk($sformatf("%s_u%0d_c[%0d]", p, g, k), ob[k].c, ex[k].c);
      chk($sformatf("%s_u%0d_a[%0d]", p, g, k), ob[k].a, ex[k].a);
    end
    fdc = (g == 1) ? fdc1 : fdc0;
    bfc = (g == 1) ? bfc1 : bfc0;
    chk($sformatf("%s_u%0d_frame_done", p, g), fdc - c0, t);
    chk($sformatf("%s_u%0d_busy_fall", p, g), bfc - c0, t + 1);
  endtask

  task automatic run_frame(input string p, input int d,
                           input bit spur, input bit poke);
    int c0;
    int n;
    dly = d;
    spur_en = spur;
    evq.delete();
    fdc0 = -1; fdc1 = -1; bfc0 = -1; bfc1 = -1;
    c0 = cyc;
    start = 1'b1;
    tick();
    n = 0;
    while (!(fdc0 >= 0 && fdc1 >= 0 && bfc0 >= 0 && bfc1 >= 0)
           && n < 20000) begin
      start = poke && (n == 3);
      tick();
      n++;
    end
    start = 1'b0;
    spur_en = 1'b0;
    chk({p, "_timeout"}, 32'(n >= 20000), 0);
    compare(p, 0, c0);
    compare(p, 1, c0);
    repeat (3) tick();
  endtask

  task automatic clear_board();
    for (int i = 0; i < 256; i++) board[i] = 3'd0;
  endtask

  task automatic random_board();
    clear_board();
    for (int i = 0; i < 200; i++)
      if ($urandom_range(0, 1) == 1) board[i] = 3'($urandom_range(1, 7));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    clear_board();
    tick();
    start = 1'b1;
    tick();
    chk_idle("reset");
    start = 1'b0;
    rst = 1'b0;
    tick();

    board[0] = 3'd5;
    run_frame("first_cell", 20, 1'b0, 1'b0);

    clear_board();
    board[199] = 3'd3;
    run_frame("last_cell", 20, 1'b0, 1'b0);

    clear_board();
    run_frame("all_empty", 5, 1'b0, 1'b0);

    random_board();
    run_frame("random", int'($urandom_range(2, 8)), 1'b1, 1'b1);

    random_board();
    dly = 6;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("midfill_u1_in_fill", 32'(cnt1 > 0), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("midfill_rst");
    repeat (4) tick();
    chk("midfill_u0_stays_idle", 32'(b0), 0);
    chk("midfill_u1_stays_idle", 32'(b1), 0);

    random_board();
    run_frame("restart", 3, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
